// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package loader_pkg;

    localparam logic [7:0] LOADER_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop input synchroniser and mid-bit sampling.
// Latency: byte/framing strobe one cycle after the stop-bit mid sample.
// No backpressure: strobes are single-cycle and must be consumed immediately.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iRx,
    output logic [7:0] oByte,
    output logic       oByteValid,
    output logic       oFrameErr
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e       state, state_d;
    logic            sync1, sync2, rx_prev;
    logic [CW-1:0]   cnt, cnt_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      shreg, shreg_d;
    logic [7:0]      byte_d;
    logic            vld_d, ferr_d;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            oByte      <= '0;
            oByteValid <= 1'b0;
            oFrameErr  <= 1'b0;
        end else begin
            sync1      <= iRx;
            sync2      <= sync1;
            rx_prev    <= sync2;
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_idx_d;
            shreg      <= shreg_d;
            oByte      <= byte_d;
            oByteValid <= vld_d;
            oFrameErr  <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        byte_d    = oByte;
        vld_d     = 1'b0;
        ferr_d    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !sync2) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {sync2, shreg[7:1]};
                    bit_idx_d = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (sync2) begin
                        vld_d  = 1'b1;
                        byte_d = shreg;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a framed subleq image over UART and writes it to CPU memory, holding the CPU in reset.
// Latency: each word is written the cycle after its 4th byte strobe; optional checksum via LOADER_CHECKSUM_EN.
// No backpressure: the memory write port must accept every oMemWe pulse.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iRx,
    output logic                  oMemWe,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [31:0]           oMemData,
    output logic                  oCpuHold,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oError,
    output logic [15:0]           oWordCount
);

    localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_WIDTH);

    logic [7:0] rx_byte;
    logic       rx_vld, rx_ferr;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .iClock     (iClock),
        .iReset     (iReset),
        .iRx        (iRx),
        .oByte      (rx_byte),
        .oByteValid (rx_vld),
        .oFrameErr  (rx_ferr)
    );

    loader_state_e         state, state_d;
    logic [7:0]            len_lo, len_lo_d;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_d, addr_d;
    logic [1:0]            byte_idx, byte_idx_d;
    logic [23:0]           asm_q, asm_d;
    logic [31:0]           data_d;
    logic [15:0]           wc_d, n_rx;
    logic                  we_d, busy_d, done_d, error_d, hold_d;
    logic                  go_done, go_error, frame_end;
    logic                  is_hdr, oversize, last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum, csum_d;
`endif

    assign is_hdr    = rx_vld && (rx_byte == LOADER_HEADER);
    assign n_rx      = {rx_byte, len_lo};
    assign oversize  = {1'b0, n_rx} > MAX_WORDS;
    assign last_word = (16'(wr_addr) == oWordCount - 16'd1);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= IDLE;
            len_lo     <= '0;
            wr_addr    <= '0;
            byte_idx   <= '0;
            asm_q      <= '0;
            oMemWe     <= 1'b0;
            oMemAddr   <= '0;
            oMemData   <= '0;
            oCpuHold   <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oError     <= 1'b0;
            oWordCount <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state      <= state_d;
            len_lo     <= len_lo_d;
            wr_addr    <= wr_addr_d;
            byte_idx   <= byte_idx_d;
            asm_q      <= asm_d;
            oMemWe     <= we_d;
            oMemAddr   <= addr_d;
            oMemData   <= data_d;
            oCpuHold   <= hold_d;
            oBusy      <= busy_d;
            oDone      <= done_d;
            oError     <= error_d;
            oWordCount <= wc_d;
`ifdef LOADER_CHECKSUM_EN
            csum       <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state;
        len_lo_d   = len_lo;
        wr_addr_d  = wr_addr;
        byte_idx_d = byte_idx;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = oMemAddr;
        data_d     = oMemData;
        hold_d     = oCpuHold;
        busy_d     = oBusy;
        done_d     = oDone;
        error_d    = oError;
        wc_d       = oWordCount;
        go_done    = 1'b0;
        go_error   = 1'b0;
        frame_end  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum;
        if (rx_vld) csum_d = csum ^ rx_byte;
`endif
        case (state)
            IDLE, ERROR: begin
                if (is_hdr) begin
                    state_d = LEN_LO;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    hold_d  = 1'b1;
                end
            end
            LEN_LO: begin
                if (rx_vld) begin
                    len_lo_d = rx_byte;
                    state_d  = LEN_HI;
`ifdef LOADER_CHECKSUM_EN
                    csum_d   = rx_byte;
`endif
                end
            end
            LEN_HI: begin
                if (rx_vld) begin
                    wc_d = n_rx;
                    if (oversize) begin
                        go_error = 1'b1;
                    end else if (n_rx == 16'd0) begin
                        frame_end = 1'b1;
                    end else begin
                        wr_addr_d  = '0;
                        byte_idx_d = '0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_vld) begin
                    byte_idx_d = byte_idx + 1'b1;
                    case (byte_idx)
                        2'd0:    asm_d[7:0]   = rx_byte;
                        2'd1:    asm_d[15:8]  = rx_byte;
                        2'd2:    asm_d[23:16] = rx_byte;
                        default: begin
                            we_d      = 1'b1;
                            addr_d    = wr_addr;
                            data_d    = {rx_byte, asm_q};
                            wr_addr_d = wr_addr + 1'b1;
                            frame_end = last_word;
                        end
                    endcase
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_vld) begin
                    if (rx_byte == csum) go_done  = 1'b1;
                    else                 go_error = 1'b1;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef LOADER_CHECKSUM_EN
        if (frame_end) state_d = CHECK;
`else
        if (frame_end) go_done = 1'b1;
`endif
        if (rx_ferr && state != IDLE) go_error = 1'b1;

        // The hold stays asserted on error so a partial image never runs.
        if (go_error) begin
            state_d = ERROR;
            busy_d  = 1'b0;
            error_d = 1'b1;
            hold_d  = 1'b1;
        end else if (go_done) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hold_d  = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed frames plus randomized frames checked against a frame-level model.
module tb_uart_program_loader;

    localparam int CPB = 8;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          cpu_hold, busy, done, err;
    logic [15:0]   wc;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .iClock     (clk),
        .iReset     (rst),
        .iRx        (rx),
        .oMemWe     (mem_we),
        .oMemAddr   (mem_addr),
        .oMemData   (mem_data),
        .oCpuHold   (cpu_hold),
        .oBusy      (busy),
        .oDone      (done),
        .oError     (err),
        .oWordCount (wc)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          byte_strobes = 0;
    int          model_wc = 0;
    logic [7:0]  tx_q[$];
    logic [35:0] obs_q[$];
    logic [35:0] exp_q[$];

    always @(negedge clk) begin
        if (mem_we) obs_q.push_back({mem_addr, mem_data});
        if (dut.u_rx.oByteValid) byte_strobes++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        if (!stop_bit) idle_bits(2 * CPB);
        rx = 1'b1;
    endtask

    // Sends tx_q; the byte at ferr_at goes out with a bad stop bit and ends the frame.
    task automatic send_q(input int ferr_at);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == ferr_at) begin
                send_byte(tx_q[i], 1'b0);
                break;
            end
            send_byte(tx_q[i], 1'b1);
            idle_bits($urandom_range(0, 3));
        end
    endtask

    task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 1; i < tx_q.size(); i++) x ^= tx_q[i];
        tx_q.push_back(x);
`endif
    endtask

    task automatic push_word(input int i);
        exp_q.push_back({4'(i), tx_q[3+4*i+3], tx_q[3+4*i+2], tx_q[3+4*i+1], tx_q[3+4*i]});
    endtask

    task automatic settle();
        int k;
        k = 0;
        repeat (12) @(posedge clk);
        while (busy && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (busy) chk("busy_timeout", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input logic e_done, input logic e_err, input logic e_hold);
        settle();
        chk({tag, "_done"}, 64'(done), 64'(e_done));
        chk({tag, "_error"}, 64'(err), 64'(e_err));
        chk({tag, "_hold"}, 64'(cpu_hold), 64'(e_hold));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_wcount"}, 64'(wc), 64'(model_wc));
        chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    int         b0, mode, n, ferr_at, nj, words;
    logic       bad;
    logic [7:0] b;
    logic [15:0] n16;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_data", 64'(mem_data), 64'd0);
        chk("rst_hold", 64'(cpu_hold), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(err), 64'd0);
        chk("rst_wcount", 64'(wc), 64'd0);
        rst = 1'b0;
        idle_bits(20);

        // two-word image
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_csum();
        send_q(-1);
        model_wc = 2;
        exp_q.push_back({4'd0, 32'h12345678});
        exp_q.push_back({4'd1, 32'hDEADBEEF});
        check_frame("two_words", 1'b1, 1'b0, 1'b0);

        // junk before header, then an empty frame
        b0 = byte_strobes;
        tx_q = '{8'h00, 8'hFF};
        send_q(-1);
        settle();
        chk("junk_busy", 64'(busy), 64'd0);
        chk("junk_done_kept", 64'(done), 64'd1);
        chk("junk_rx_bytes", 64'(byte_strobes - b0), 64'd2);
        tx_q = '{8'hA5, 8'h00, 8'h00};
        add_csum();
        send_q(-1);
        model_wc = 0;
        check_frame("zero_len", 1'b1, 1'b0, 1'b0);

        // framing error mid-data, then recovery
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        send_q(5);
        model_wc = 1;
        check_frame("ferr", 1'b0, 1'b1, 1'b1);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        add_csum();
        send_q(-1);
        exp_q.push_back({4'd0, 32'h11223344});
        check_frame("recover", 1'b1, 1'b0, 1'b0);

        // oversize length
        tx_q = '{8'hA5, 8'h11, 8'h00};
        send_q(-1);
        model_wc = 17;
        check_frame("oversize", 1'b0, 1'b1, 1'b1);

        // short low glitch gives no byte; receiver still works afterwards
        b0 = byte_strobes;
        @(posedge clk);
        rx = 1'b0;
        repeat (3) @(posedge clk);
        idle_bits(40);
        @(negedge clk);
        chk("glitch_bytes", 64'(byte_strobes - b0), 64'd0);
        chk("glitch_error_kept", 64'(err), 64'd1);
        tx_q = '{8'h3C};
        send_q(-1);
        settle();
        chk("after_glitch_bytes", 64'(byte_strobes - b0), 64'd1);

        // reset mid-DATA
        tx_q = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_q(-1);
        repeat (12) @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_we", 64'(mem_we), 64'd0);
        chk("midrst_addr", 64'(mem_addr), 64'd0);
        chk("midrst_data", 64'(mem_data), 64'd0);
        chk("midrst_hold", 64'(cpu_hold), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_error", 64'(err), 64'd0);
        chk("midrst_wcount", 64'(wc), 64'd0);
        rst = 1'b0;
        tx_q.delete();
        for (int i = 0; i < 11; i++) tx_q.push_back(8'(8'h10 + i));
        send_q(-1);
        model_wc = 0;
        exp_q.push_back({4'd0, 32'h04030201});
        check_frame("midrst", 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_q(-1);
        model_wc = 1;
        exp_q.push_back({4'd0, 32'h04030201});
        check_frame("csum_ok", 1'b1, 1'b0, 1'b0);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        send_q(-1);
        exp_q.push_back({4'd0, 32'h04030201});
        check_frame("csum_bad", 1'b0, 1'b1, 1'b1);
`endif

        // randomized frames
        for (int t = 0; t < 14; t++) begin
            mode    = $urandom_range(0, 9);
            nj      = $urandom_range(0, 2);
            ferr_at = -1;
            bad     = 1'b0;

            tx_q.delete();
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                tx_q.push_back(b);
            end
            send_q(($urandom_range(0, 1) == 1) ? 0 : -1);
            settle();
            chk("rnd_junk_busy", 64'(busy), 64'd0);

            if (t == 0)         n = 16;
            else if (mode == 0) n = 17 + $urandom_range(0, 3);
            else                n = $urandom_range(0, 5);
            n16 = 16'(n);
            tx_q = '{8'hA5, n16[7:0], n16[15:8]};
            if (n <= 16) begin
                for (int j = 0; j < 4 * n; j++) tx_q.push_back(8'($urandom));
                if (mode == 3 && n > 0) tx_q[3] = 8'hA5;
                if (mode == 2 && n > 0) ferr_at = $urandom_range(1, 2 + 4 * n);
`ifdef LOADER_CHECKSUM_EN
                add_csum();
                if (mode >= 7) begin
                    bad = 1'b1;
                    tx_q[tx_q.size()-1] = tx_q[tx_q.size()-1] ^ 8'h5A;
                end
`endif
            end

            if (n > 16) begin
                model_wc = n;
                send_q(-1);
                check_frame("rnd_oversize", 1'b0, 1'b1, 1'b1);
            end else if (ferr_at >= 0) begin
                if (ferr_at > 2) model_wc = n;
                words = (ferr_at > 3) ? (ferr_at - 3) / 4 : 0;
                for (int i = 0; i < words; i++) push_word(i);
                send_q(ferr_at);
                check_frame("rnd_ferr", 1'b0, 1'b1, 1'b1);
            end else begin
                model_wc = n;
                for (int i = 0; i < n; i++) push_word(i);
                send_q(-1);
                check_frame("rnd_frame", !bad, bad, bad);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Inbound companion to the board's debug display path: receives a subleq program over a serial line on a GPIO pin and writes it into CPU memory.
- Holds the CPU in reset while loading.
- Sits beside the subleq core in the board top level. It drives the memory write port and gates the CPU reset.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- ADDR_WIDTH, 8, word-address width of CPU memory.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  synchronous, active-high reset.
- iRx  in  1  asynchronous UART line, idle high, 8N1, LSB first.
- oMemWe  out  1  one-cycle memory write strobe.
- oMemAddr  out  ADDR_WIDTH  word address for the write.
- oMemData  out  32  word to write.
- oCpuHold  out  1  high while a load is in progress or failed; OR it into the CPU reset.
- oBusy  out  1  high from header accept until DONE/ERROR.
- oDone  out  1  level; high after a successful load until the next header.
- oError  out  1  level; high after a failed load until the next header.
- oWordCount  out  16  length field of the last accepted frame.

Behaviour:
- Reset values:
  - All outputs 0, except oCpuHold = 0.
  - Rx synchroniser flops = 1.
  - FSM in IDLE.
- Reset mid-load aborts immediately with no further writes; memory contents already written are left as-is.
- iRx passes through a 2-flop synchroniser before any use.
- Byte receiver:
  - Falling edge on the synchronised line starts reception.
  - At CLKS_PER_BIT/2 the start bit is re-sampled; if high, it is a glitch and the receiver returns to idle with no byte.
  - 8 data bits are sampled every CLKS_PER_BIT, LSB first.
  - The stop bit is sampled at mid-bit. Stop = 1 gives a 1-cycle byte strobe. Stop = 0 gives a 1-cycle framing-error strobe and no byte.
  - After the stop sample the receiver re-arms immediately, so back-to-back bytes are accepted.
- Frame format: header 0xA5, LEN_LO, LEN_HI, then N = {LEN_HI, LEN_LO} words of 4 bytes each, little-endian within the word.
- Loader FSM:
  - IDLE: non-0xA5 bytes and framing errors are ignored. On 0xA5: oDone = 0, oError = 0, oBusy = 1, oCpuHold = 1, go to LEN_LO.
  - LEN_LO → LEN_HI: latch the length bytes. After LEN_HI, set oWordCount = N.
    - N = 0: go to DONE.
    - N > 2^ADDR_WIDTH: go to ERROR.
    - Otherwise: address = 0, go to DATA.
  - DATA:
    - Bytes shift into a 32-bit assembler, byte 0 into bits [7:0].
    - On the 4th byte, oMemWe is asserted the next cycle with the current oMemAddr and oMemData.
    - The address increments after each write and the byte index returns to 0.
    - After write N-1, go to DONE.
    - oMemAddr/oMemData hold their values when oMemWe is low.
  - DONE: oBusy = 0, oCpuHold = 0, oDone = 1. Go to IDLE on the next cycle; the oDone level persists.
  - ERROR: entered on a framing error in any non-IDLE state, or on an oversize N. oBusy = 0, oError = 1, oCpuHold stays 1 (CPU must not run a partial image). Only a new 0xA5 header, or iReset, leaves ERROR; that header restarts the load.
- A byte strobe and a framing error never coincide.
- A header byte arriving mid-frame is treated as data, not as a restart.
- Address never wraps: the oversize check guarantees the last address is 2^ADDR_WIDTH - 1.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - One extra byte follows the data. It must equal the XOR of all bytes from LEN_LO through the last data byte.
  - The FSM adds a CHECK state. Match goes to DONE; mismatch goes to ERROR.
  - Words are still written during DATA, and the hold persists on mismatch.
  - N = 0 frames also carry the checksum byte.
- Not defined: no CHECK state and no checksum byte; DATA goes directly to DONE.

Decomposition:
- Package loader_pkg holds:
  - LOADER_HEADER = 8'hA5.
  - The FSM state enum: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- One sub-module, uart_rx_byte. It owns the synchroniser, the bit timing and the framing check, and outputs oByte[7:0], oByteValid and oFrameErr.

Test Plan (sim CLKS_PER_BIT = 8, ADDR_WIDTH = 4):
- Send A5 02 00, then 78 56 34 12 and EF BE AD DE → two oMemWe pulses: addr 0 data 0x12345678, addr 1 data 0xDEADBEEF. oDone = 1, oCpuHold = 0, oWordCount = 2.
- Bytes 00 FF then A5 00 00 → the first two are ignored (no oBusy); then DONE with zero writes and oWordCount = 0.
- A5 01 00, 2 data bytes, then a byte with stop bit = 0 → ERROR: oError = 1, oCpuHold = 1, no write. A new A5 01 00 plus 4 bytes → write at addr 0, oDone = 1, oError = 0.
- A5 11 00 (N = 17 > 16) → ERROR right after LEN_HI, no writes.
- A 3-cycle low glitch on iRx in IDLE → no byte strobe. iReset pulsed mid-DATA → all outputs 0, FSM in IDLE, no further oMemWe.
- With LOADER_CHECKSUM_EN: A5 01 00 01 02 03 04 + checksum 0x05 → DONE; the same frame with checksum 0x06 → ERROR, and the word was still written at addr 0.
